uart_txrx_param: RTL

UART_TXRX_PARAM -- requirements
Module: uart_txrx_param

---
 rtl/uart_txrx_param.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_txrx_param.sv
// Parameterised full-duplex UART: one transmitter and one receiver sharing a
// clock. Frame is start(0), DATA_BITS LSB-first, optional parity, then
// STOP_BITS stop bits (1). Every bit lasts BAUD_DIV clock cycles. The receiver
// samples mid-bit after a synchronised falling edge and reports parity and
// framing errors alongside each received word.
module uart_txrx_param #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_DIV  = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          PAR_EN    = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 1);

    // Parity bit for a data word: XOR of the bits, inverted for odd parity.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_r, tx_state_next_s;
    logic [BW-1:0]        tx_baud_r, tx_baud_next_s;
    logic [NW-1:0]        tx_bit_r, tx_bit_next_s;
    logic                 tx_stop_r, tx_stop_next_s;
    logic [DATA_BITS-1:0] tx_shift_r, tx_shift_next_s;
    logic                 tx_par_r, tx_par_next_s;
    logic                 txd_next_s;
    logic                 tx_wrap_s;

    // TX next-state: walk the frame one baud period per bit; txd is decoded from the next state so it is registered.
    always_comb begin
        tx_state_next_s = tx_state_r;
        tx_baud_next_s  = tx_baud_r;
        tx_bit_next_s   = tx_bit_r;
        tx_stop_next_s  = tx_stop_r;
        tx_shift_next_s = tx_shift_r;
        tx_par_next_s   = tx_par_r;
        tx_wrap_s       = (tx_baud_r == BAUD_LAST);
        if (tx_wrap_s) begin
            tx_baud_next_s = {BW{1'b0}};
        end else begin
            tx_baud_next_s = tx_baud_r + 1'b1;
        end
        case (tx_state_r)
            TX_IDLE: begin
                tx_baud_next_s = {BW{1'b0}};
                if (tx_valid) begin
                    tx_state_next_s = TX_START;
                    tx_shift_next_s = tx_data;
                    tx_par_next_s   = parity_of(tx_data);
                    tx_bit_next_s   = {NW{1'b0}};
                    tx_stop_next_s  = 1'b0;
                end else begin
                    tx_state_next_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_wrap_s) begin
                    tx_state_next_s = TX_DATA;
                end else begin
                    tx_state_next_s = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_wrap_s) begin
                    if (tx_bit_r == BIT_LAST) begin
                        tx_state_next_s = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_next_s   = tx_bit_r + 1'b1;
                        tx_shift_next_s = {1'b0, tx_shift_r[DATA_BITS-1:1]};
                    end
                end else begin
                    tx_state_next_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_wrap_s) begin
                    tx_state_next_s = TX_STOP;
                end else begin
                    tx_state_next_s = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_wrap_s) begin
                    if (tx_stop_r == STOP_LAST) begin
                        tx_state_next_s = TX_IDLE;
                    end else begin
                        tx_stop_next_s = 1'b1;
                    end
                end else begin
                    tx_state_next_s = TX_STOP;
                end
            end
            default: begin
                tx_state_next_s = TX_IDLE;
            end
        endcase
        case (tx_state_next_s)
            TX_START:  txd_next_s = 1'b0;
            TX_DATA:   txd_next_s = tx_shift_next_s[0];
            TX_PARITY: txd_next_s = tx_par_next_s;
            default:   txd_next_s = 1'b1;
        endcase
    end

    // TX state register and registered serial/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_baud_r  <= {BW{1'b0}};
            tx_bit_r   <= {NW{1'b0}};
            tx_stop_r  <= 1'b0;
            tx_shift_r <= {DATA_BITS{1'b0}};
            tx_par_r   <= 1'b0;
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
        end else begin
            tx_state_r <= tx_state_next_s;
            tx_baud_r  <= tx_baud_next_s;
            tx_bit_r   <= tx_bit_next_s;
            tx_stop_r  <= tx_stop_next_s;
            tx_shift_r <= tx_shift_next_s;
            tx_par_r   <= tx_par_next_s;
            txd        <= txd_next_s;
            tx_ready   <= (tx_state_next_s == TX_IDLE);
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]           sync_r;
    logic                 rx_s;
    rx_state_t            rx_state_r, rx_state_next_s;
    logic [BW-1:0]        rx_baud_r, rx_baud_next_s;
    logic [NW-1:0]        rx_bit_r, rx_bit_next_s;
    logic [DATA_BITS-1:0] rx_shift_r, rx_shift_next_s;
    logic                 rx_par_r, rx_par_next_s;
    logic [DATA_BITS-1:0] rx_data_next_s;
    logic                 rx_valid_next_s, rx_perr_next_s, rx_ferr_next_s;
    logic                 rx_sample_s;

    assign rx_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd};
        end
    end

    // RX next-state: find start mid-point, then sample each later bit one baud period apart.
    always_comb begin
        rx_state_next_s = rx_state_r;
        rx_bit_next_s   = rx_bit_r;
        rx_shift_next_s = rx_shift_r;
        rx_par_next_s   = rx_par_r;
        rx_data_next_s  = rx_data;
        rx_valid_next_s = 1'b0;
        rx_perr_next_s  = rx_parity_err;
        rx_ferr_next_s  = rx_frame_err;
        rx_sample_s     = (rx_state_r == RX_START) ? (rx_baud_r == HALF_LAST)
                                                   : (rx_baud_r == BAUD_LAST);
        if (rx_sample_s) begin
            rx_baud_next_s = {BW{1'b0}};
        end else begin
            rx_baud_next_s = rx_baud_r + 1'b1;
        end
        case (rx_state_r)
            RX_IDLE: begin
                rx_baud_next_s = {BW{1'b0}};
                if (!rx_s) begin
                    rx_state_next_s = RX_START;
                end else begin
                    rx_state_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_sample_s) begin
                    rx_state_next_s = rx_s ? RX_IDLE : RX_DATA;
                    rx_bit_next_s   = {NW{1'b0}};
                end else begin
                    rx_state_next_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_sample_s) begin
                    rx_shift_next_s = {rx_s, rx_shift_r[DATA_BITS-1:1]};
                    if (rx_bit_r == BIT_LAST) begin
                        rx_state_next_s = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_next_s = rx_bit_r + 1'b1;
                    end
                end else begin
                    rx_state_next_s = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_sample_s) begin
                    rx_par_next_s   = rx_s;
                    rx_state_next_s = RX_STOP;
                end else begin
                    rx_state_next_s = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_sample_s) begin
                    rx_valid_next_s = 1'b1;
                    rx_data_next_s  = rx_shift_r;
                    rx_perr_next_s  = PAR_EN & (parity_of(rx_shift_r) ^ rx_par_r);
                    rx_ferr_next_s  = ~rx_s;
                    // A low stop bit may be a break: wait for the line to go high first.
                    rx_state_next_s = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_state_next_s = RX_STOP;
                end
            end
            RX_WAIT_HIGH: begin
                rx_baud_next_s = {BW{1'b0}};
                if (rx_s) begin
                    rx_state_next_s = RX_IDLE;
                end else begin
                    rx_state_next_s = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_state_next_s = RX_IDLE;
            end
        endcase
    end

    // RX state register and registered word/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r    <= RX_IDLE;
            rx_baud_r     <= {BW{1'b0}};
            rx_bit_r      <= {NW{1'b0}};
            rx_shift_r    <= {DATA_BITS{1'b0}};
            rx_par_r      <= 1'b0;
            rx_data       <= {DATA_BITS{1'b0}};
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_state_r    <= rx_state_next_s;
            rx_baud_r     <= rx_baud_next_s;
            rx_bit_r      <= rx_bit_next_s;
            rx_shift_r    <= rx_shift_next_s;
            rx_par_r      <= rx_par_next_s;
            rx_data       <= rx_data_next_s;
            rx_valid      <= rx_valid_next_s;
            rx_parity_err <= rx_perr_next_s;
            rx_frame_err  <= rx_ferr_next_s;
        end
    end

endmodule
